// File: rtl/mips_io_port.sv
// rtl/mips_io_port.sv - Host/CPU byte port: 4-deep RX FIFO with interrupt handshake, TX holding register.
// Optional ack timeout enabled by defining IO_PORT_TIMEOUT_EN.
module mips_io_port (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_wr_valid,
    input  logic [7:0] host_wr_data,
    output logic       host_wr_ready,
    output logic [7:0] data_in,
    output logic       interrupt,
    input  logic       int_ack,
    input  logic [7:0] data_out,
    input  logic       out_strobe,
    output logic       host_rd_valid,
    output logic [7:0] host_rd_data,
    input  logic       host_rd_ready,
    output logic       overrun,
    output logic       int_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        hold_valid_q, hold_valid_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        overrun_q, overrun_d;
    logic        push;
    logic        pop;
    logic        timeout_hit;

    // Ready is a function of the registered count only, so a full FIFO
    // refuses a push even when a pop happens in the same cycle.
    assign host_wr_ready = (count_q != 3'd4);
    assign push          = host_wr_valid & host_wr_ready;
    assign pop           = (state_q == ST_ASSERT) & int_ack;
    assign data_in       = (count_q != 3'd0) ? mem_q[rd_ptr_q] : 8'h00;
    assign interrupt     = (state_q == ST_ASSERT);
    assign host_rd_valid = hold_valid_q;
    assign host_rd_data  = hold_data_q;
    assign overrun       = overrun_q;

`ifdef IO_PORT_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       int_timeout_q, int_timeout_d;

    assign timeout_hit = (state_q == ST_ASSERT) & ~int_ack & (to_cnt_q == 8'd254);
    assign int_timeout = int_timeout_q;

    always_comb begin
        to_cnt_d      = to_cnt_q;
        int_timeout_d = int_timeout_q | timeout_hit;
        if (state_q == ST_IDLE) begin
            to_cnt_d = 8'd0;
        end else if (state_q == ST_ASSERT) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q      <= 8'd0;
            int_timeout_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            int_timeout_q <= int_timeout_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign int_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (count_q != 3'd0) state_d = ST_ASSERT;
            ST_ASSERT:  if (int_ack || timeout_hit) state_d = ST_HOLDOFF;
            ST_HOLDOFF: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {2'b00, push} - {2'b00, pop};
        if (push) begin
            mem_d[wr_ptr_q] = host_wr_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
    end

    // A strobe into a stalled holding register is dropped and flagged.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        overrun_d    = overrun_q;
        if (out_strobe && (!hold_valid_q || host_rd_ready)) begin
            hold_valid_d = 1'b1;
            hold_data_d  = data_out;
        end else if (out_strobe) begin
            overrun_d = 1'b1;
        end else if (hold_valid_q && host_rd_ready) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule
